bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It sits directly downstream of the binary source, for example the 6-bit operand stage. It consumes one unsigned binary word per handshake and produces packed decimal digits for display or printing logic. Processing is one bit per clock, which trades latency for a small adder footprint.

Parameters:
- WIDTH, 6, bit width of the unsigned binary input.
- DIGITS, 2, number of 4-bit BCD digits produced. Elaboration fails with $fatal if 10**DIGITS < 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_bin is valid.
- in_ready  output  1  converter can accept a word; high only in IDLE.
- in_bin  input  WIDTH  unsigned binary value.
- out_valid  output  1  out_bcd holds a completed result.
- out_ready  input  1  consumer accepts the result.
- out_bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset: on a rising edge with rst=1, state goes to IDLE and internal shift/BCD registers clear. Outputs after reset: in_ready=1, out_valid=0, out_bcd=0, busy=0. rst overrides all other inputs, including mid-conversion and while holding a result.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture in_bin into the shift register, clear the BCD accumulator, load count=WIDTH, go to SHIFT.
- SHIFT:
  - Each cycle, every BCD digit >= 5 gets +3 (combinational, all digits in parallel).
  - Then the {BCD, bin} concatenation shifts left by 1, MSB of bin first.
  - count decrements each cycle. When count reaches 1, do the final shift and go to DONE.
  - Exactly WIDTH SHIFT cycles.
  - in_valid is ignored (in_ready=0).
- DONE:
  - out_valid=1; out_bcd registered and stable until handshake.
  - On out_valid && out_ready: go to IDLE.
  - out_valid stays high with out_bcd unchanged while out_ready=0.
- Latency: accept edge at cycle 0. out_valid is first visible after edge WIDTH, i.e. WIDTH+1 clock edges from accept to handshake-capable. For WIDTH=6: 6 cycles after the accept edge.
- Throughput: one word per WIDTH+2 cycles (accept, WIDTH shifts, output handshake). There is no overlap: in_ready stays low in DONE.
- out_bcd may be left unchanged outside DONE. Its value is only meaningful while out_valid=1.
- Boundaries:
  - in_bin=0 gives all-zero BCD.
  - in_bin=2**WIDTH-1 gives the maximum value with no overflow, guaranteed by the DIGITS check.
  - in_valid held high across the DONE→IDLE transition is accepted on the first IDLE cycle.
  - X on in_bin while in_valid=0 must not propagate.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- Defined:
  - Extra output out_blank [DIGITS-1:0], valid with out_valid and registered alongside out_bcd.
  - Bit i=1 when digit i and all higher digits are 0 (leading-zero blanking).
  - Bit 0 is forced to 0 so the units digit always shows.
  - Reset value: all zeros.
- Undefined: the port and its logic are absent. Core behaviour is identical.

Decomposition:
- Package bin2bcd_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - constant BCD_DIGIT_W=4.
  - function min_digits(width) used by the elaboration check.
- Sub-module bcd_adjust_digit: combinational 4-bit in/out, adds 3 when input >= 5. Instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then in_bin=6'b110111 (55) with out_ready=1 → out_valid after 6 cycles, out_bcd=8'h55, one-cycle out_valid.
- in_bin=0, then in_bin=63 back-to-back with in_valid held → out_bcd=8'h00, then 8'h63. The second accept happens the cycle after the first output handshake; in_ready=0 throughout SHIFT/DONE.
- Backpressure: in_bin=42, out_ready=0 for 5 cycles after out_valid → out_bcd=8'h42 stable, in_ready=0; releasing out_ready gives one handshake and a return to IDLE.
- Reset mid-SHIFT (rst at the 3rd shift cycle) → next cycle in_ready=1, out_valid=0, busy=0. A subsequent in_bin=9 yields 8'h09.
- With BIN2BCD_BLANK_EN: in_bin=7 → out_bcd=8'h07, out_blank=2'b10. in_bin=0 → out_blank=2'b10. in_bin=10 → out_blank=2'b00.
- Exhaustive sweep 0..63 against a reference model (value/10, value%10) → all match. Each result arrives exactly 6 cycles after its accept edge.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Optional leading-zero blanking output is enabled by BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;

  // Decimal digits needed to hold 2**width-1.
  function automatic int min_digits(input int width);
    longint v;
    int     d;
    v = (longint'(1) << width) - 1;
    d = 1;
    v = v / 10;
    while (v > 0) begin
      v = v / 10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_adjust_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is >= 5.
// Purely combinational; one instance per output digit.
module bcd_adjust_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_BLANK_EN to add the out_blank leading-zero mask output.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          busy
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]             out_blank
`endif
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_chk
    $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [BW-1:0]   adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adjust_digit u_adj (
      .d_i (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = in_bin;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // {adjusted BCD, bin} shifted left by one, bin MSB enters BCD LSB
        bcd_d = BW'(adj << 1) | BW'(bin_q[WIDTH-1]);
        bin_d = WIDTH'(bin_q << 1);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_above;

  always_comb begin
    blank_d    = blank_q;
    zero_above = 1'b1;
    if (state_q == SHIFT && cnt_q == CW'(1)) begin
      for (int i = DIGITS - 1; i >= 0; i--) begin
        zero_above = zero_above &&
                     (bcd_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
        blank_d[i] = zero_above;
      end
      blank_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) blank_q <= '0;
    else     blank_q <= blank_d;
  end

  assign out_blank = blank_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver queues expected results on
// accept, a negedge monitor pops and compares on each output handshake.
module tb_bin2bcd_seq;

  typedef struct {
    logic [7:0] bcd;
    logic [1:0] blank;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_bin = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_bcd;
  logic       busy;
`ifdef BIN2BCD_BLANK_EN
  logic [1:0] out_blank;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_edge = -100;
  exp_t sbq[$];

  bin2bcd_seq #(.WIDTH(6), .DIGITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
`ifdef BIN2BCD_BLANK_EN
    ,
    .out_blank (out_blank)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [5:0] v, input logic [7:0] e,
                      input logic [1:0] b, input bit hold,
                      output int acc);
    int   t;
    exp_t x;
    in_valid = 1'b1;
    in_bin   = v;
    t = 0;
    acc = -1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t = t + 1;
      if (t > 50) begin
        chk("accept_timeout", 32'(t), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    x.bcd = e;
    x.blank = b;
    x.acc = cyc + 1;
    acc = x.acc;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (!hold) begin
      in_valid = 1'b0;
      in_bin   = 'x;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clk);
      t = t + 1;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each presented result against the queue head.
  initial begin : monitor
    bit   prev_v;
    bit   prev_hs;
    exp_t cur;
    prev_v  = 1'b0;
    prev_hs = 1'b0;
    cur.bcd = '0;
    cur.blank = '0;
    cur.acc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v  = 1'b0;
        prev_hs = 1'b0;
        continue;
      end
      if (prev_hs) chk("one_cycle_valid", 32'(out_valid), 32'd0);
      prev_hs = 1'b0;
      if (out_valid) begin
        if (!prev_v) begin
          if (sbq.size() == 0) begin
            chk("unexpected_out", 32'(out_bcd), 32'hFFFF);
          end else begin
            cur = sbq[0];
            chk("out_bcd", 32'(out_bcd), 32'(cur.bcd));
            chk("latency", 32'(cyc), 32'(cur.acc + 6));
`ifdef BIN2BCD_BLANK_EN
            chk("out_blank", 32'(out_blank), 32'(cur.blank));
`endif
          end
        end else begin
          chk("hold_bcd", 32'(out_bcd), 32'(cur.bcd));
        end
        chk("in_ready_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          if (sbq.size() != 0) void'(sbq.pop_front());
          hs_edge = cyc + 1;
          prev_hs = 1'b1;
        end
      end else if (busy) begin
        chk("in_ready_shift", 32'(in_ready), 32'd0);
      end
      prev_v = out_valid && !out_ready;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a0, a1;
    int t;
    logic [7:0] e;
    logic [1:0] b;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef BIN2BCD_BLANK_EN
    chk("rst_out_blank", 32'(out_blank), 32'd0);
`endif
    @(posedge clk);
    #1;

    // 55 with out_ready=1
    send(6'd55, 8'h55, 2'b00, 1'b0, a0);
    drain();

    // 0 then 63 back-to-back, in_valid held
    send(6'd0, 8'h00, 2'b10, 1'b1, a0);
    send(6'd63, 8'h63, 2'b00, 1'b0, a1);
    chk("b2b_accept", 32'(a1), 32'(hs_edge + 1));
    drain();

    // Backpressure on 42
    out_ready = 1'b0;
    send(6'd42, 8'h42, 2'b00, 1'b0, a0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t = t + 1;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_idle", 32'(in_ready), 32'd1);
    chk("bp_queue", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset during the third shift cycle
    send(6'd21, 8'h21, 2'b00, 1'b0, a0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_bcd", 32'(out_bcd), 32'd0);
    @(posedge clk);
    #1;
    send(6'd9, 8'h09, 2'b10, 1'b0, a0);
    drain();

    // Blanking boundary values
    send(6'd7, 8'h07, 2'b10, 1'b0, a0);
    send(6'd10, 8'h10, 2'b00, 1'b0, a0);
    drain();

    // Full sweep against value/10, value%10
    for (int v = 0; v < 64; v++) begin
      e = {4'(v / 10), 4'(v % 10)};
      b = (v < 10) ? 2'b10 : 2'b00;
      send(6'(v), e, b, 1'b0, a0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
